// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage of a 16-bit pipeline. Issues requests to an
// instruction memory with variable latency and writes either the returned
// word or a bubble (NOP_INSTR) into the IF/ID register every cycle.
//
// Behaviour in brief:
//   REQ   : request outstanding at pc; a returned word is delivered, or parked
//           in the hold buffer if decode is stalled.
//   HOLD  : parked word waits for the stall to clear; no memory request.
//   DRAIN : a redirect arrived while a request was in flight; that request is
//           finished on its old address and its word thrown away.
//   HALT  : an HLT opcode (4'hF) was delivered; only redirect or rst leave.
//
// A redirect wins over every other event and always writes a NOP to IF/ID.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous, active-high reset
//   stall        in   1   hazard stall: IF/ID keeps its contents
//   redirect     in   1   taken branch / flush from a later stage
//   redirect_pc  in   16  redirect target (bit 0 forced to 0)
//   imem_req     out  1   instruction memory request
//   imem_addr    out  16  instruction memory address
//   imem_ready   in   1   one-cycle strobe: imem_data valid
//   imem_data    in   16  instruction word
//   fd_enable    out  1   IF/ID write enable
//   fd_pc        out  16  PC written to IF/ID
//   fd_instr     out  16  instruction written to IF/ID
//   halted       out  1   high while in HALT
//   fetch_count  out  16  real instructions delivered to IF/ID (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hE000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic        fd_enable,
  output logic [15:0] fd_pc,
  output logic [15:0] fd_instr,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Registered state
  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_buf;         // word parked while decode is stalled
  logic [15:0] r_drain_addr;  // address of the in-flight request being drained
  logic [15:0] r_fetch_count;

  // Next-state values
  state_t      w_next_state;
  logic [15:0] w_pc_next;
  logic [15:0] w_buf_next;
  logic [15:0] w_drain_next;
  logic        w_count_inc;

  // Helpers
  logic [15:0] w_pc_plus2;
  logic [15:0] w_redirect_target;
  logic [15:0] w_deliver_word;
  logic        w_deliver;

  // Natural 16-bit overflow gives the required modulo-2^16 wrap.
  assign w_pc_plus2        = r_pc + 16'd2;
  assign w_redirect_target = {redirect_pc[15:1], 1'b0};
  assign fetch_count       = r_fetch_count;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    w_next_state   = r_state;
    w_pc_next      = r_pc;
    w_buf_next     = r_buf;
    w_drain_next   = r_drain_addr;
    w_count_inc    = 1'b0;
    w_deliver      = 1'b0;
    w_deliver_word = NOP_INSTR;

    imem_req  = 1'b0;
    imem_addr = r_pc;
    fd_enable = !stall;
    fd_pc     = r_pc;
    fd_instr  = NOP_INSTR;
    halted    = 1'b0;

    if (rst) begin
      // Quiet outputs while reset is held; the registers reload on the edge.
      fd_enable = 1'b0;
      fd_pc     = RESET_PC;
    end else begin
      unique case (r_state)
        S_REQ: begin
          imem_req = 1'b1;
          if (redirect) begin
            fd_enable = 1'b1;
            w_pc_next = w_redirect_target;
            if (imem_ready) begin
              // Response lands in the same cycle: nothing left in flight.
              w_next_state = S_REQ;
            end else begin
              // The old request is still open in memory; finish it before
              // issuing from the new target.
              w_next_state = S_DRAIN;
              w_drain_next = r_pc;
            end
          end else if (imem_ready) begin
            if (stall) begin
              fd_enable    = 1'b0;
              w_buf_next   = imem_data;
              w_next_state = S_HOLD;
            end else begin
              w_deliver      = 1'b1;
              w_deliver_word = imem_data;
            end
          end
          // Otherwise: bubble with defaults (NOP, fd_pc = pc, enable = !stall).
        end

        S_HOLD: begin
          if (redirect) begin
            fd_enable    = 1'b1;
            w_pc_next    = w_redirect_target;
            w_next_state = S_REQ;
          end else begin
            // The parked word is presented even while stalled; IF/ID only
            // takes it once fd_enable rises.
            fd_instr = r_buf;
            fd_pc    = w_pc_plus2;
            if (!stall) begin
              w_deliver      = 1'b1;
              w_deliver_word = r_buf;
            end
          end
        end

        S_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = r_drain_addr;
          if (redirect) begin
            fd_enable    = 1'b1;
            w_pc_next    = w_redirect_target;
            w_next_state = imem_ready ? S_REQ : S_DRAIN;
          end else if (imem_ready) begin
            // Stale word is dropped; fetching resumes from the new pc.
            w_next_state = S_REQ;
          end
        end

        S_HALT: begin
          halted = 1'b1;
          if (redirect) begin
            fd_enable    = 1'b1;
            w_pc_next    = w_redirect_target;
            w_next_state = S_REQ;
          end
        end

        default: begin
          w_next_state = S_REQ;
        end
      endcase

      // Common delivery path shared by REQ and HOLD.
      if (w_deliver) begin
        fd_enable    = 1'b1;
        fd_instr     = w_deliver_word;
        fd_pc        = w_pc_plus2;
        w_pc_next    = w_pc_plus2;
        w_count_inc  = 1'b1;
        w_next_state = (w_deliver_word[15:12] == HLT_OPCODE) ? S_HALT : S_REQ;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the hold buffer is a single register, so it is reset along with
    // the rest of the state; fd_instr can then never show an unknown word.
    if (rst) begin
      r_state       <= S_REQ;
      r_pc          <= RESET_PC;
      r_buf         <= NOP_INSTR;
      r_drain_addr  <= RESET_PC;
      r_fetch_count <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      r_state       <= w_next_state;
      r_pc          <= w_pc_next;
      r_buf         <= w_buf_next;
      r_drain_addr  <= w_drain_next;
      r_fetch_count <= r_fetch_count + {15'd0, w_count_inc};
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small behavioural instruction memory with
// programmable latency answers the main instance; a second instance with
// RESET_PC = 16'hFFFE runs against a zero-wait memory to exercise pc wrap.
// Expected deliveries go into a scoreboard queue when a scenario is set up
// and are popped by a monitor whenever IF/ID is written with a real word.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'hE000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_data;
  logic        fd_enable;
  logic [15:0] fd_pc;
  logic [15:0] fd_instr;
  logic        halted;
  logic [15:0] fetch_count;

  // Wrap instance signals
  logic        wr_imem_req;
  logic [15:0] wr_imem_addr;
  logic        wr_fd_enable;
  logic [15:0] wr_fd_pc;
  logic [15:0] wr_fd_instr;
  logic        wr_halted;
  logic [15:0] wr_fetch_count;

  // Memory model controls
  logic        mem_en;
  logic        stray;       // ready pulse regardless of request
  int          lat;
  int          wait_cnt;
  logic [15:0] mem [0:511];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_data   (imem_data),
    .fd_enable   (fd_enable),
    .fd_pc       (fd_pc),
    .fd_instr    (fd_instr),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (16'h0000),
    .imem_req    (wr_imem_req),
    .imem_addr   (wr_imem_addr),
    .imem_ready  (wr_imem_req),
    .imem_data   (16'h1234),
    .fd_enable   (wr_fd_enable),
    .fd_pc       (wr_fd_pc),
    .fd_instr    (wr_fd_instr),
    .halted      (wr_halted),
    .fetch_count (wr_fetch_count)
  );

  // Latency model: ready once the request has waited lat cycles.
  assign imem_ready = (mem_en && imem_req && (wait_cnt >= lat)) || stray;
  assign imem_data  = mem[imem_addr[9:1]];

  always @(posedge clk) begin
    if (!mem_en || !imem_req || imem_ready) wait_cnt <= 0;
    else                                    wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every real IF/ID write must match the next expected word.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst && fd_enable && fd_instr !== NOP) begin
      if (sb_q.size() > 0) exp = sb_q.pop_front();
      else                 exp = 32'hDEAD_DEAD;
      check("sb_deliver", {fd_pc, fd_instr}, exp);
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0BAD;
    mem[16'h0000 >> 1] = 16'h1111;
    mem[16'h0002 >> 1] = 16'h2222;
    mem[16'h0004 >> 1] = 16'h3333;
    mem[16'h0006 >> 1] = 16'h4444;
    mem[16'h0010 >> 1] = 16'hF000;
    mem[16'h0012 >> 1] = 16'h7777;
    mem[16'h0040 >> 1] = 16'h5555;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_en = 1'b0; stray = 1'b0; lat = 0;

    // ---- Reset state ----
    adv(); adv();
    smp();
    check("rst_imem_req",  imem_req,    1'b0);
    check("rst_fd_enable", fd_enable,   1'b0);
    check("rst_fd_instr",  fd_instr,    NOP);
    check("rst_fd_pc",     fd_pc,       16'h0000);
    check("rst_halted",    halted,      1'b0);
    check("rst_count",     fetch_count, 16'h0000);
    check("rst_w_fd_pc",   wr_fd_pc,    16'hFFFE);

    // ---- Zero-wait fetch of two words; wrap instance runs alongside ----
    adv(); rst = 1'b0; mem_en = 1'b1; lat = 0;
    sb_q.push_back({16'h0002, 16'h1111});
    sb_q.push_back({16'h0004, 16'h2222});
    smp();
    check("a_req",       imem_req,     1'b1);
    check("a_addr0",     imem_addr,    16'h0000);
    check("w_addr_rst",  wr_imem_addr, 16'hFFFE);
    check("w_fd_pc",     wr_fd_pc,     16'h0000);
    adv();
    smp();
    check("a_addr2",     imem_addr,    16'h0002);
    check("w_addr_wrap", wr_imem_addr, 16'h0000);
    check("w_count",     wr_fetch_count, 16'h0001);
    adv(); mem_en = 1'b0;
    smp();
    check("a_count",     fetch_count,  16'h0002);
    check("a_bubble_en", fd_enable,    1'b1);
    check("a_bubble_in", fd_instr,     NOP);
    check("a_bubble_pc", fd_pc,        16'h0004);

    // ---- Stall for 3 cycles while 0x2222 returns ----
    adv(); rst = 1'b1;
    smp();
    check("b_rst_req", imem_req, 1'b0);
    adv(); rst = 1'b0; mem_en = 1'b1;
    sb_q.push_back({16'h0002, 16'h1111});
    sb_q.push_back({16'h0004, 16'h2222});
    smp();
    check("b_count0", fetch_count, 16'h0000);
    adv(); stall = 1'b1;
    smp();
    check("b_addr2",   imem_addr, 16'h0002);
    check("b_stall1",  fd_enable, 1'b0);
    adv();
    smp();
    check("b_hold_req",   imem_req,  1'b0);
    check("b_stall2",     fd_enable, 1'b0);
    check("b_hold_instr", fd_instr,  16'h2222);
    check("b_hold_pc",    fd_pc,     16'h0004);
    adv();
    smp();
    check("b_stall3", fd_enable, 1'b0);
    adv(); stall = 1'b0; mem_en = 1'b0;
    smp();
    check("b_release_en", fd_enable, 1'b1);
    adv();
    smp();
    check("b_next_addr", imem_addr,   16'h0004);
    check("b_next_req",  imem_req,    1'b1);
    check("b_count",     fetch_count, 16'h0002);

    // ---- Redirect to 0x0041 during a memory wait at 0x0006 ----
    adv(); mem_en = 1'b1; lat = 0;
    sb_q.push_back({16'h0006, 16'h3333});
    smp();
    adv(); lat = 4;
    smp();
    check("c_addr6", imem_addr, 16'h0006);
    adv();
    adv(); redirect = 1'b1; redirect_pc = 16'h0041;
    smp();
    check("c_redir_en", fd_enable, 1'b1);
    check("c_redir_in", fd_instr,  NOP);
    check("c_redir_pc", fd_pc,     16'h0006);
    adv(); redirect = 1'b0;
    smp();
    check("c_drain_req",  imem_req,  1'b1);
    check("c_drain_addr", imem_addr, 16'h0006);
    check("c_drain_pc",   fd_pc,     16'h0040);
    adv();
    smp();
    check("c_drain_ready", imem_ready, 1'b1);
    check("c_drain_nop",   fd_instr,   NOP);
    adv(); mem_en = 1'b0;
    smp();
    check("c_new_addr", imem_addr,   16'h0040);
    check("c_count",    fetch_count, 16'h0003);

    // ---- Redirect + stall + ready together, then HLT at 0x0010 ----
    adv(); mem_en = 1'b1; lat = 0; redirect = 1'b1; stall = 1'b1; redirect_pc = 16'h0010;
    smp();
    check("d_rs_en", fd_enable, 1'b1);
    check("d_rs_in", fd_instr,  NOP);
    check("d_rs_pc", fd_pc,     16'h0040);
    adv(); redirect = 1'b0; stall = 1'b0;
    sb_q.push_back({16'h0012, 16'hF000});
    smp();
    check("d_addr10",  imem_addr,   16'h0010);
    check("d_count_k", fetch_count, 16'h0003);
    adv();
    smp();
    check("d_halted",   halted,      1'b1);
    check("d_halt_req", imem_req,    1'b0);
    check("d_halt_en",  fd_enable,   1'b1);
    check("d_halt_in",  fd_instr,    NOP);
    check("d_halt_pc",  fd_pc,       16'h0012);
    check("d_count",    fetch_count, 16'h0004);
    adv(); stall = 1'b1; stray = 1'b1;
    smp();
    check("d_halt_stall", fd_enable, 1'b0);
    check("d_stray_in",   fd_instr,  NOP);
    adv(); stall = 1'b0; stray = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
    smp();
    check("d_exit_en", fd_enable, 1'b1);
    check("d_exit_pc", fd_pc,     16'h0012);
    adv(); redirect = 1'b0; mem_en = 1'b0;
    smp();
    check("d_addr100", imem_addr, 16'h0100);
    check("d_req100",  imem_req,  1'b1);
    check("d_unhalt",  halted,    1'b0);

    // ---- Second redirect in DRAIN, then reset out of DRAIN ----
    adv(); redirect = 1'b1; redirect_pc = 16'h0200;
    smp();
    check("e_redir_pc", fd_pc, 16'h0100);
    adv(); redirect_pc = 16'h0301;
    smp();
    check("e_drain_addr", imem_addr, 16'h0100);
    check("e_drain_pc",   fd_pc,     16'h0200);
    adv(); redirect = 1'b0;
    smp();
    check("e_still_drain", imem_addr, 16'h0100);
    check("e_pc300",       fd_pc,     16'h0300);
    adv(); rst = 1'b1;
    smp();
    check("e_rst_req", imem_req, 1'b0);
    check("e_rst_pc",  fd_pc,    16'h0000);
    adv(); rst = 1'b0;
    smp();
    check("e_post_req",   imem_req,    1'b1);
    check("e_post_addr",  imem_addr,   16'h0000);
    check("e_post_count", fetch_count, 16'h0000);
    check("e_post_halt",  halted,      1'b0);

    check("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'hE000 (PCS R0), SHALL be the bubble instruction.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 stall  input  1  SHALL be the hazard stall; when high, IF/ID holds its contents.
REQ-006 redirect  input  1  SHALL be the taken-branch/flush request from a later stage.
REQ-007 redirect_pc  input  16  SHALL be the redirect target; bit 0 is ignored and forced to 0.
REQ-008 imem_req  output  1  SHALL be the instruction-memory request.
REQ-009 imem_addr  output  16  SHALL be the instruction-memory address.
REQ-010 imem_ready  input  1  SHALL be high for one cycle when imem_data is valid for the held request.
REQ-011 imem_data  input  16  SHALL be the instruction word, valid only when imem_ready is high.
REQ-012 fd_enable  output  1  SHALL be the write enable into the fetch/decode register.
REQ-013 fd_pc  output  16  SHALL be the PC value written to IF/ID.
REQ-014 fd_instr  output  16  SHALL be the instruction written to IF/ID.
REQ-015 halted  output  1  SHALL be high while in HALT.
REQ-016 fetch_count  output  16  SHALL be the count of real instructions delivered to IF/ID.

Function
REQ-017 The FSM SHALL have four states: REQ, HOLD, DRAIN, HALT. State, pc, the hold buffer and fetch_count are registered.
REQ-018 REQ: imem_req=1 and imem_addr=pc; addr stays stable until imem_ready.
REQ-019 REQ, imem_ready=1, stall=0: fd_enable=1, fd_instr=imem_data, fd_pc=pc+2; pc<=pc+2; fetch_count+1.
REQ-020 REQ, imem_ready=1, stall=1: imem_data goes into the hold buffer; next state HOLD; pc unchanged.
REQ-021 REQ, imem_ready=0: fd_enable=!stall, fd_instr=NOP_INSTR, fd_pc=pc (bubble); fetch_count unchanged.
REQ-022 HOLD: imem_req=0; fd_instr=buffer, fd_pc=pc+2, fd_enable=!stall. When stall=0: pc<=pc+2, fetch_count+1, next state REQ.
REQ-023 An instruction delivered with opcode [15:12]=4'hF (HLT) SHALL move the FSM to HALT; pc<=pc+2 still applies.
REQ-024 HALT: imem_req=0; halted=1; fd_enable=!stall with NOP_INSTR and fd_pc=pc; exits only on redirect or rst.
REQ-025 redirect SHALL take priority over stall and all other events in every state.
REQ-026 In the redirect cycle: fd_enable=1, fd_instr=NOP_INSTR, fd_pc=pc; any imem_data or buffered word is discarded and not counted; pc<={redirect_pc[15:1],1'b0}.
REQ-027 Redirect in REQ with imem_ready=0: next state DRAIN. Otherwise: next state REQ.
REQ-028 DRAIN: imem_req=1 on the old address; the returned word is discarded; fd_enable=!stall with NOP; on imem_ready, next state REQ.
REQ-029 A second redirect in DRAIN SHALL update pc and keep the FSM in DRAIN.
REQ-030 pc+2 and fetch_count SHALL wrap modulo 2^16 (16'hFFFE+2=16'h0000).
REQ-031 imem_ready while imem_req=0 SHALL be ignored.

Reset
REQ-032 While rst=1: pc<=RESET_PC, state<=REQ, buffer<=NOP_INSTR, fetch_count<=0. Outputs during rst: imem_req=0, fd_enable=0, fd_instr=NOP_INSTR, fd_pc=RESET_PC, halted=0.
REQ-033 rst SHALL abort any state, including DRAIN and HALT, with no outstanding request tracked. The first cycle after rst deasserts SHALL issue imem_req=1 with imem_addr=RESET_PC.

Verification
REQ-034 Zero-wait memory, words 0x1111, 0x2222 at 0x0000/0x0002 -> fd_pc=0x0002 then 0x0004, fd_instr in order, fetch_count=2.
REQ-035 stall=1 for 3 cycles as 0x2222 returns -> HOLD, fd_enable=0 for 3 cycles, then 0x2222 delivered once, pc=0x0004, no re-request of 0x0002.
REQ-036 Redirect to 0x0041 during a 4-cycle memory wait at 0x0006 -> NOP written, DRAIN until ready, stale word discarded, next imem_addr=0x0040.
REQ-037 Fetch 0xF000 at 0x0010 -> delivered, halted=1, imem_req=0, NOPs with fd_pc=0x0012; redirect to 0x0100 -> imem_addr=0x0100.
REQ-038 redirect and stall both high with imem_ready=1 -> fd_enable=1 with NOP, data discarded, fetch_count unchanged.
REQ-039 RESET_PC=16'hFFFE, one fetch -> pc wraps to 0x0000. rst asserted in DRAIN -> imem_addr=RESET_PC one cycle after release.
